// File: rtl/spi_frame_ctrl_if.sv
// Word-in / payload-out stream bundle for spi_frame_ctrl.
// The master side feeds received words and accepts payload; the slave side is the controller.
interface spi_frame_ctrl_if;
  logic [15:0] word_in;
  logic        word_valid;
  logic [15:0] out_data;
  logic [3:0]  out_channel;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (output word_in, word_valid, out_ready,
                  input  out_data, out_channel, out_last, out_valid);
  modport slave  (input  word_in, word_valid, out_ready,
                  output out_data, out_channel, out_last, out_valid);
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: sync/header/payload/checksum sequencing with buffered,
// checksum-gated payload release and error classification/counting.
module spi_frame_ctrl #(
  parameter logic [15:0] SYNC_WORD   = 16'hA55A,
  parameter int          MAX_LEN     = 8,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs_n,
  spi_frame_ctrl_if.slave bus,
  output logic           frame_ok,
  output logic           frame_err,
  output logic [2:0]     err_code,
  output logic [15:0]    ok_cnt,
  output logic [15:0]    err_cnt,
  output logic           busy
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, DRAIN} state_e;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_BAD_LEN = 3'd1, E_BAD_CSUM = 3'd2,
    E_TIMEOUT = 3'd3, E_ABORT = 3'd4, E_OVERRUN = 3'd5
  } err_e;

  state_e state_q, state_d;
  err_e   err_d;
  logic   err_set, ok_set, pay_wr, hdr_ld;
  logic   wv, hs, cs_hi, tmo_exp, hdr_bad;

  logic [1:0]              cs_pipe;
  logic [TW-1:0]           tmo_q;
  logic [7:0]              len_q, idx_q, rd_q;
  logic [15:0]             sum_q;
  logic [3:0]              chan_q;
  logic [MAX_LEN-1:0][15:0] fbuf_q;

  assign wv      = bus.word_valid;
  assign hs      = bus.out_valid & bus.out_ready;
  assign cs_hi   = cs_pipe[1];
  assign tmo_exp = (tmo_q == TW'(TIMEOUT_CYC - 1)) & ~wv;
  assign hdr_bad = (bus.word_in[7:0] == 8'd0) || (int'(bus.word_in[7:0]) > MAX_LEN) ||
                   (bus.word_in[11:8] != 4'd0);
  assign busy    = (state_q != IDLE);
  assign bus.out_channel = chan_q;

  // Abort outranks a same-cycle word, which in turn clears any pending timeout.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_d   = E_NONE;
    ok_set  = 1'b0;
    pay_wr  = 1'b0;
    hdr_ld  = 1'b0;
    case (state_q)
      IDLE: if (wv && bus.word_in == SYNC_WORD) state_d = HDR;
      HDR, PAYLOAD, CSUM: begin
        if (cs_hi) begin
          err_set = 1'b1; err_d = E_ABORT; state_d = IDLE;
        end else if (wv) begin
          if (state_q == HDR) begin
            if (hdr_bad) begin
              err_set = 1'b1; err_d = E_BAD_LEN; state_d = IDLE;
            end else begin
              hdr_ld = 1'b1; state_d = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            pay_wr = 1'b1;
            if (idx_q == len_q - 8'd1) state_d = CSUM;
          end else if (bus.word_in == sum_q) begin
            ok_set = 1'b1; state_d = DRAIN;
          end else begin
            err_set = 1'b1; err_d = E_BAD_CSUM; state_d = IDLE;
          end
        end else if (tmo_exp) begin
          err_set = 1'b1; err_d = E_TIMEOUT; state_d = IDLE;
        end
      end
      DRAIN: begin
        if (wv) begin
          err_set = 1'b1; err_d = E_OVERRUN;
        end
        if (hs && bus.out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cs_pipe       <= 2'b11;
      tmo_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rd_q          <= '0;
      sum_q         <= '0;
      chan_q        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
      ok_cnt        <= '0;
      err_cnt       <= '0;
    end else begin
      state_q   <= state_d;
      cs_pipe   <= {cs_pipe[0], cs_n};
      frame_ok  <= ok_set;
      frame_err <= err_set;
      if (err_set) begin
        err_code <= err_d;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (ok_set && ok_cnt != 16'hFFFF) ok_cnt <= ok_cnt + 16'd1;
      if (wv || state_q == IDLE || state_q == DRAIN) tmo_q <= '0;
      else                                           tmo_q <= tmo_q + TW'(1);
      if (hdr_ld) begin
        len_q  <= bus.word_in[7:0];
        chan_q <= bus.word_in[15:12];
        sum_q  <= bus.word_in;
        idx_q  <= '0;
      end
      if (pay_wr) begin
        sum_q <= sum_q + bus.word_in;
        idx_q <= idx_q + 8'd1;
      end
      // Release starts from slot 0 in the same edge the checksum is accepted.
      if (ok_set) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= fbuf_q[0];
        bus.out_last  <= (len_q == 8'd1);
        rd_q          <= 8'd1;
      end else if (hs) begin
        if (bus.out_last) begin
          bus.out_valid <= 1'b0;
        end else begin
          bus.out_data <= fbuf_q[rd_q[IW-1:0]];
          bus.out_last <= (rd_q == len_q - 8'd1);
          rd_q         <= rd_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pay_wr) fbuf_q[idx_q[IW-1:0]] <= bus.word_in;
  end
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Frame controller that sits downstream of the SPI word receiver (16-bit words with a one-cycle valid strobe) and sequences the raw word stream into checked frames. Layout: sync word, header (channel + length), payload, 16-bit additive checksum. Payload is buffered and released to consumers over a valid/ready stream only after the checksum passes. Malformed, stalled, aborted or overrunning frames are flagged and counted.

## Interface
- SYNC_WORD, 16'hA55A, frame start marker
- MAX_LEN, 8, maximum payload words per frame (1..255); also the frame buffer depth
- TIMEOUT_CYC, 1000000, idle cycles allowed between words inside a frame (10 ms at 100 MHz)

- clk  in  1  system clock (100 MHz); one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- word_in  in  16  received word from SPI receiver
- word_valid  in  1  one-cycle strobe, word_in valid
- cs_n  in  1  raw SPI chip select (active-low, asynchronous); 2-flop synchronized internally
- out_data  out  16  payload word
- out_channel  out  4  channel from header, constant for the whole frame
- out_last  out  1  marks final payload word of frame
- out_valid  out  1  payload word available
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- frame_ok  out  1  one-cycle pulse, frame passed checksum
- frame_err  out  1  one-cycle pulse, frame rejected
- err_code  out  3  cause of last error, held until next error: 1 BAD_LEN, 2 BAD_CSUM, 3 TIMEOUT, 4 ABORT, 5 OVERRUN
- ok_cnt  out  16  good frames, saturating at 16'hFFFF
- err_cnt  out  16  rejected frames/dropped words, saturating at 16'hFFFF
- busy  out  1  high in any state other than IDLE

## Operation
- Header word: [15:12] channel, [11:8] reserved (must be 0), [7:0] len.
- Checksum word = (header + all payload words) mod 2^16. The sync word is excluded.
- States: IDLE, HDR, PAYLOAD, CSUM, DRAIN.
  - IDLE: words != SYNC_WORD are discarded silently. SYNC_WORD goes to HDR.
  - HDR: if len==0, len>MAX_LEN or reserved!=0, emit BAD_LEN and return to IDLE. Otherwise latch channel and len, set sum=header, go to PAYLOAD.
  - PAYLOAD: write word to buffer[idx], add it to sum, idx++. When idx reaches len, go to CSUM.
  - CSUM: if word==sum, emit frame_ok, increment ok_cnt, go to DRAIN. Otherwise emit BAD_CSUM and return to IDLE.
  - DRAIN: present buffer[0..len-1] in order. After the handshake on the last word, go to IDLE.
- Errors:
  - Every error pulses frame_err, loads err_code and increments err_cnt.
  - No payload from a rejected frame ever reaches out_*.
- TIMEOUT:
  - Applies in HDR, PAYLOAD and CSUM.
  - The counter clears on each word_valid.
  - If TIMEOUT_CYC consecutive cycles pass with no word_valid, raise the error and go to IDLE.
- ABORT:
  - In HDR, PAYLOAD or CSUM, a synchronized cs_n high raises the error and goes to IDLE.
  - cs_n is ignored in IDLE and DRAIN.
  - If abort and word_valid occur in the same cycle, abort wins and the word is dropped.
- OVERRUN:
  - A word_valid in DRAIN drops the word and raises the error.
  - DRAIN continues unaffected.
  - A sync word arriving in DRAIN is lost, so the next frame is missed.
- Checksum compare uses full 16-bit wrap-around arithmetic.

## Timing
- Reset values: out_valid=0, out_data=0, out_channel=0, out_last=0, frame_ok=0, frame_err=0, err_code=0, ok_cnt=0, err_cnt=0, busy=0; state IDLE.
- The state transition takes effect the cycle after the word_valid that causes it.
- frame_ok and the first out_valid are both asserted 1 cycle after the checksum word's word_valid.
- frame_err is asserted 1 cycle after the offending word, timeout expiry or synchronized cs_n edge.
  - ABORT therefore appears about 3 cycles after the raw cs_n rises.
- Stream handshake:
  - out_data, out_channel and out_last stay stable while out_valid & !out_ready.
  - With out_ready held high, one word transfers per cycle.
  - out_valid falls the cycle after the last handshake, and state is IDLE on that cycle.
- Back-to-back frames: a sync word may be accepted on the first IDLE cycle after DRAIN.
- Asynchronous reset mid-frame or mid-drain:
  - Outputs take reset values immediately.
  - Buffered payload is discarded.

## Test plan
- Good frame A55A, 3002, 1234, 0F0F, 5145 with out_ready=1:
  - frame_ok pulses; out_channel=3.
  - out_data 1234 then 0F0F, out_last on 0F0F.
  - ok_cnt=1.
- Same frame with checksum 5146:
  - frame_err pulses, err_code=2, err_cnt=1.
  - out_valid never asserts.
- Header 3000 (len 0), then header 3009 with MAX_LEN=8:
  - err_code=1 for each; err_cnt=2; state IDLE.
- Good frame with out_ready toggled 1,0,0,1:
  - Each word is held stable while stalled.
  - Exactly 2 handshakes occur; out_last only on the second.
- Stall with TIMEOUT_CYC=16: sync, header 3002, one payload word, then silence.
  - frame_err with err_code=3 arrives 16 cycles after the last word.
  - Repeat, but raise cs_n after the header: err_code=4.
- Good frame, out_ready=0, then word 00AA with word_valid during DRAIN:
  - err_code=5, err_cnt=1.
  - Drain still delivers 1234 and 0F0F intact once out_ready=1.
